rtc_bus_responder: RTL and testbench

RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

---
 rtl/rtc_bus_responder_pkg.sv | 26 ++
 rtl/rtc_phase_timer.sv | 34 +++
 rtl/rtc_bus_responder.sv | 183 ++++++++++++++++++
 tb/tb_rtc_bus_responder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_responder_pkg.sv
// Shared definitions for the RTC bus responder: FSM encoding, register map, STATUS bits, timing defaults.
// No logic here; latency and backpressure are properties of the modules that import it.
package rtc_bus_responder_pkg;

    localparam int RTC_PULSE_CYC_DEF = 8;
    localparam int RTC_GAP_CYC_DEF   = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_A_SETUP  = 3'd1;
    localparam logic [2:0] ST_A_STROBE = 3'd2;
    localparam logic [2:0] ST_GAP      = 3'd3;
    localparam logic [2:0] ST_D_STROBE = 3'd4;
    localparam logic [2:0] ST_HOLD     = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    localparam logic [7:0] DIR_ADDR   = 8'h00;
    localparam logic [7:0] DIR_WDATA  = 8'h01;
    localparam logic [7:0] DIR_CMD    = 8'h02;
    localparam logic [7:0] DIR_RDATA  = 8'h03;
    localparam logic [7:0] DIR_STATUS = 8'h04;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVERRUN = 2;

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase counter: loaded with a cycle count on state entry, expire_o marks the last cycle of the phase.
// Latency: loaded value visible next cycle; no backpressure, saturates at zero.
module rtc_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic       expire_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A load of 0 or 1 both give a single-cycle phase.
    assign expire_o = (cnt_q <= 8'd1);

endmodule

// File: rtl/rtc_bus_responder.sv
// Micro-port register file plus FSM driving a multiplexed-A/D RTC bus (address phase, data phase).
// in_port is one cycle behind dir; no backpressure: a start while busy is dropped and flagged as overrun.
module rtc_bus_responder
    import rtc_bus_responder_pkg::*;
#(
    parameter int PULSE_CYC = RTC_PULSE_CYC_DEF,
    parameter int GAP_CYC   = RTC_GAP_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dir,
    input  logic [7:0] out_port,
    input  logic       writestrobe,
    input  logic       read_strobe,
    input  logic       actRTC,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_sel,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC);
    localparam logic [7:0] GAP_LD   = 8'(GAP_CYC);

    logic [2:0] state_q, state_d;
    logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, in_port_q, in_port_d;
    logic       is_wr_q, is_wr_d, done_q, done_d, ovr_q, ovr_d, irq_q, irq_d;
    logic       tmr_load, tmr_expire;
    logic [7:0] tmr_val;
    logic [7:0] status;
    logic       wr_acc, rd_acc, start_wr, start_rd, busy, in_done;

    assign wr_acc   = writestrobe & actRTC;
    assign rd_acc   = read_strobe & actRTC;
    assign start_wr = wr_acc & (dir == DIR_WDATA);
    assign start_rd = wr_acc & (dir == DIR_CMD) & out_port[0];
    assign busy     = (state_q != ST_IDLE);
    assign in_done  = (state_q == ST_DONE);

    always_comb begin
        status               = 8'h00;
        status[STAT_BUSY]    = busy;
        status[STAT_DONE]    = done_q | in_done;
        status[STAT_OVERRUN] = ovr_q;
    end

    rtc_phase_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        is_wr_d  = is_wr_q;
        tmr_load = 1'b0;
        tmr_val  = 8'd1;
        case (state_q)
            ST_IDLE: if (start_wr || start_rd) begin
                state_d  = ST_A_SETUP;
                is_wr_d  = start_wr;
                tmr_load = 1'b1;
            end
            ST_A_SETUP: if (tmr_expire) begin
                state_d  = ST_A_STROBE;
                tmr_load = 1'b1;
                tmr_val  = PULSE_LD;
            end
            ST_A_STROBE: if (tmr_expire) begin
                state_d  = ST_GAP;
                tmr_load = 1'b1;
                tmr_val  = GAP_LD;
            end
            ST_GAP: if (tmr_expire) begin
                state_d  = ST_D_STROBE;
                tmr_load = 1'b1;
                tmr_val  = PULSE_LD;
            end
            ST_D_STROBE: if (tmr_expire) begin
                state_d  = ST_HOLD;
                tmr_load = 1'b1;
                tmr_val  = GAP_LD;
            end
            ST_HOLD: if (tmr_expire) begin
                state_d  = ST_DONE;
                tmr_load = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Set beats clear when a flag is raised and read back in the same cycle.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = done_q;
        ovr_d   = ovr_q;
        if (rd_acc && dir == DIR_STATUS) ovr_d = 1'b0;
        if (rd_acc && dir == DIR_RDATA)  done_d = 1'b0;
        if (in_done) done_d = 1'b1;
        if (wr_acc && busy && (dir == DIR_ADDR || dir == DIR_WDATA || (dir == DIR_CMD && out_port[0]))) begin
            ovr_d = 1'b1;
        end
        if (wr_acc && !busy && dir == DIR_ADDR)  addr_d  = out_port;
        if (wr_acc && !busy && dir == DIR_WDATA) wdata_d = out_port;
        if (state_q == ST_D_STROBE && !is_wr_q && tmr_expire) rdata_d = ad_in;
        irq_d     = in_done | (irq_q & ~interrupt_ack);
        in_port_d = 8'h00;
        if (actRTC) begin
            case (dir)
                DIR_RDATA:  in_port_d = rdata_q;
                DIR_STATUS: in_port_d = status;
                default:    in_port_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            is_wr_q   <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            irq_q     <= 1'b0;
            in_port_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            irq_q     <= irq_d;
            in_port_q <= in_port_d;
        end
    end

    assign in_port   = in_port_q;
    assign interrupt = irq_q | in_done;

    // Bus pins decode straight from registered state so reset forces them idle asynchronously.
    always_comb begin
        cs_n   = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        ad_sel = 1'b0;
        ad_oe  = 1'b0;
        ad_out = 8'h00;
        case (state_q)
            ST_A_SETUP, ST_A_STROBE: begin
                cs_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr_q;
                wr_n   = (state_q != ST_A_STROBE);
            end
            ST_GAP, ST_D_STROBE, ST_HOLD: begin
                cs_n   = 1'b0;
                ad_sel = 1'b1;
                ad_oe  = is_wr_q;
                ad_out = is_wr_q ? wdata_q : 8'h00;
                if (state_q == ST_D_STROBE) begin
                    wr_n = ~is_wr_q;
                    rd_n = is_wr_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Randomised and directed stimulus for rtc_bus_responder, checked every cycle against a
// transaction-level model that places each bus phase by its offset from the accepted start.
module tb_rtc_bus_responder;

    localparam int P    = 8;
    localparam int G    = 4;
    localparam int LAST = 1 + 2 * P + 2 * G;  // offset of the DONE cycle
    localparam int CAP  = 2 * P + G;          // offset of the last rd_n-low cycle

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] dir = 8'h00, out_port = 8'h00;
    logic       writestrobe = 1'b0, read_strobe = 1'b0, actRTC = 1'b0, interrupt_ack = 1'b0;
    logic [7:0] in_port, ad_out, ad_in;
    logic       interrupt, cs_n, rd_n, wr_n, ad_sel, ad_oe;
    logic [7:0] rtc_val = 8'h00;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state: transaction active, accepted-start cycle, op type, register images.
    int         n = 0, s = 0;
    bit         act = 1'b0, m_wr = 1'b0, m_done = 1'b0, m_ovr = 1'b0, m_irq = 1'b0;
    logic [7:0] m_addr = 8'h00, m_wdata = 8'h00, m_rdata = 8'h00, m_inport = 8'h00;

    always #5 clk = ~clk;

    assign ad_in = (!rd_n) ? rtc_val : 8'h00;

    rtc_bus_responder #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
        .clk           (clk),
        .reset         (reset),
        .dir           (dir),
        .out_port      (out_port),
        .writestrobe   (writestrobe),
        .read_strobe   (read_strobe),
        .actRTC        (actRTC),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .cs_n          (cs_n),
        .rd_n          (rd_n),
        .wr_n          (wr_n),
        .ad_sel        (ad_sel),
        .ad_out        (ad_out),
        .ad_oe         (ad_oe),
        .ad_in         (ad_in)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin : model
        int         off;
        bit         busy, in_done;
        logic [7:0] st;
        if (!reset) begin
            n = 0; s = 0; act = 1'b0; m_wr = 1'b0; m_done = 1'b0; m_ovr = 1'b0; m_irq = 1'b0;
            m_addr = 8'h00; m_wdata = 8'h00; m_rdata = 8'h00; m_inport = 8'h00;
        end else begin
            off     = n - s;
            busy    = act;
            in_done = act && (off == LAST);
            st      = {5'b0, m_ovr, m_done | in_done, busy};
            m_inport = !actRTC ? 8'h00 : (dir == 8'h03) ? m_rdata : (dir == 8'h04) ? st : 8'h00;
            if (act && !m_wr && off == CAP) m_rdata = rtc_val;
            if (read_strobe && actRTC && dir == 8'h03) m_done = 1'b0;
            if (read_strobe && actRTC && dir == 8'h04) m_ovr = 1'b0;
            if (in_done) m_done = 1'b1;
            m_irq = in_done | (m_irq & ~interrupt_ack);
            if (in_done) act = 1'b0;
            if (writestrobe && actRTC) begin
                if (dir == 8'h00) begin
                    if (busy) m_ovr = 1'b1; else m_addr = out_port;
                end else if (dir == 8'h01) begin
                    if (busy) m_ovr = 1'b1;
                    else begin m_wdata = out_port; act = 1'b1; s = n + 1; m_wr = 1'b1; end
                end else if (dir == 8'h02 && out_port[0]) begin
                    if (busy) m_ovr = 1'b1;
                    else begin act = 1'b1; s = n + 1; m_wr = 1'b0; end
                end
            end
            n = n + 1;
        end
    end

    task automatic mon_check();
        int         off;
        logic       e_cs, e_rd, e_wr, e_sel, e_oe, in_done;
        logic [7:0] e_ad;
        off  = n - s;
        e_cs = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_sel = 1'b0; e_oe = 1'b0; e_ad = 8'h00;
        in_done = act && (off == LAST);
        if (act && off < LAST) begin
            e_cs = 1'b0;
            if (off <= P) begin
                e_oe = 1'b1; e_ad = m_addr;
                if (off >= 1) e_wr = 1'b0;
            end else begin
                e_sel = 1'b1; e_oe = m_wr; e_ad = m_wdata;
                if (off > P + G && off <= CAP) begin
                    if (m_wr) e_wr = 1'b0; else e_rd = 1'b0;
                end
            end
        end
        check("cs_n", 32'(cs_n), 32'(e_cs));
        check("rd_n", 32'(rd_n), 32'(e_rd));
        check("wr_n", 32'(wr_n), 32'(e_wr));
        check("ad_sel", 32'(ad_sel), 32'(e_sel));
        check("ad_oe", 32'(ad_oe), 32'(e_oe));
        if (e_oe) check("ad_out", 32'(ad_out), 32'(e_ad));
        if (!reset) check("ad_out_rst", 32'(ad_out), 32'h0);
        check("in_port", 32'(in_port), 32'(m_inport));
        check("interrupt", 32'(interrupt), 32'(m_irq | in_done));
        check("rd_wr_excl", 32'(rd_n | wr_n), 32'h1);
        check("oe_while_rd", 32'(ad_oe & ~rd_n), 32'h0);
    endtask

    task automatic cyc1(input logic [7:0] d, input logic [7:0] v, input logic ws, input logic rs,
                        input logic a, input logic ack);
        dir = d; out_port = v; writestrobe = ws; read_strobe = rs; actRTC = a; interrupt_ack = ack;
        @(posedge clk);
        #1;
        writestrobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic wreg(input logic [7:0] d, input logic [7:0] v);
        cyc1(d, v, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic rreg(input logic [7:0] d);
        cyc1(d, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        fork
            forever begin @(negedge clk); mon_check(); end
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", 32'(cs_n), 32'h1);
        check("rst_ad_out", 32'(ad_out), 32'h0);
        check("rst_in_port", 32'(in_port), 32'h0);
        check("rst_irq", 32'(interrupt), 32'h0);
        reset = 1'b1; actRTC = 1'b1;
        idle(2);

        // Write transaction
        wreg(8'h00, 8'h21);
        wreg(8'h01, 8'h45);
        check("wr_setup_ad", 32'(ad_out), 32'h21);
        check("wr_setup_cs", 32'(cs_n), 32'h0);
        idle(1);
        check("wr_astrobe", 32'(wr_n), 32'h0);
        idle(P + G);
        check("wr_dstrobe", 32'(wr_n), 32'h0);
        check("wr_data_ad", 32'(ad_out), 32'h45);
        idle(LAST - (1 + P + G));
        check("wr_done_irq", 32'(interrupt), 32'h1);
        idle(1);
        rreg(8'h04);
        check("wr_status", 32'(in_port), 32'h02);

        // Read transaction
        rtc_val = 8'h59;
        wreg(8'h00, 8'h22);
        wreg(8'h02, 8'h01);
        idle(1 + P + G);
        check("rd_strobe", 32'(rd_n), 32'h0);
        check("rd_oe", 32'(ad_oe), 32'h0);
        idle(LAST - (1 + P + G) + 1);
        cyc1(8'h03, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rdata_mux", 32'(in_port), 32'h59);
        rreg(8'h03);
        check("rdata_rd", 32'(in_port), 32'h59);
        rreg(8'h04);
        check("done_cleared", 32'(in_port), 32'h00);

        // Overrun while busy
        wreg(8'h02, 8'h01);
        idle(3);
        wreg(8'h02, 8'h01);
        rreg(8'h04);
        check("ovr_status", 32'(in_port), 32'h05);
        rreg(8'h04);
        check("ovr_cleared", 32'(in_port), 32'h01);
        idle(LAST);

        // Write with actRTC low
        cyc1(8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("noact_cs", 32'(cs_n), 32'h1);
        rreg(8'h04);
        check("noact_status", 32'(in_port), 32'h02);
        rreg(8'h03);
        check("noact_rdata", 32'(in_port), 32'h59);

        // Ack coinciding with DONE
        cyc1(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("irq_ack_clr", 32'(interrupt), 32'h0);
        wreg(8'h01, 8'h3C);
        idle(LAST);
        check("irq_in_done", 32'(interrupt), 32'h1);
        cyc1(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("irq_ack_on_done", 32'(interrupt), 32'h1);
        idle(2);
        check("irq_held", 32'(interrupt), 32'h1);
        cyc1(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("irq_second_ack", 32'(interrupt), 32'h0);

        // Reset during the data strobe
        wreg(8'h01, 8'hA5);
        idle(1 + P + G + 2);
        check("pre_rst_wr", 32'(wr_n), 32'h0);
        #3 reset = 1'b0;
        #1;
        check("arst_cs", 32'(cs_n), 32'h1);
        check("arst_wr", 32'(wr_n), 32'h1);
        check("arst_rd", 32'(rd_n), 32'h1);
        check("arst_oe", 32'(ad_oe), 32'h0);
        check("arst_irq", 32'(interrupt), 32'h0);
        @(posedge clk);
        #1;
        idle(1);
        reset = 1'b1;
        idle(LAST + 3);
        check("no_irq_after_abort", 32'(interrupt), 32'h0);
        wreg(8'h00, 8'h33);
        wreg(8'h01, 8'h77);
        check("post_rst_ad", 32'(ad_out), 32'h33);
        idle(LAST);
        check("post_rst_irq", 32'(interrupt), 32'h1);
        idle(1);
        rreg(8'h04);
        check("post_rst_status", 32'(in_port), 32'h02);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int         op;
            logic [7:0] v;
            logic       a, ack;
            op  = int'($urandom_range(0, 9));
            a   = ($urandom_range(0, 7) != 0);
            ack = ($urandom_range(0, 5) == 0);
            v   = 8'($urandom);
            case (op)
                0: cyc1(8'h00, v, 1'b1, 1'b0, a, ack);
                1: cyc1(8'h01, v, 1'b1, 1'b0, a, ack);
                2: begin rtc_val = 8'($urandom); cyc1(8'h02, v, 1'b1, 1'b0, a, ack); end
                3: cyc1(8'h03, 8'h00, 1'b0, 1'b1, a, ack);
                4: cyc1(8'h04, 8'h00, 1'b0, 1'b1, a, ack);
                5: cyc1(8'($urandom_range(5, 255)), v, 1'b1, 1'b0, a, ack);
                6: cyc1(8'($urandom), v, 1'b0, 1'b1, a, ack);
                default: repeat ($urandom_range(1, 20))
                    cyc1(8'($urandom_range(0, 6)), 8'h00, 1'b0, 1'b0, a, ack);
            endcase
        end
        idle(LAST + 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
